// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a keeper-held tristate bus: one-hot output
// enables with forced all-off turnaround between owners and optional hold limit.
module tristate_bus_arbiter #(
    parameter int N           = 4,
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 8,
    parameter int CW          = 4,
    localparam int IW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  REQ,
    output logic [N-1:0]  GNT,
    output logic [N-1:0]  OE,
    output logic [IW-1:0] OWNER,
    output logic          PARKED,
    output logic          PREEMPT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_TURN
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [CW-1:0] turn_q, turn_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          preempt_q, preempt_d;
    logic          parked_q, parked_d;

    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] win_next;
    logic [N-1:0]  win_onehot;
    logic          owner_req;
    logic          limit_hit;
    int            cand;

    // Scan upward from the rotating pointer, wrapping modulo N.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!win_found && REQ[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    assign win_next = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign win_onehot[gi] = win_found && (win_idx == IW'(gi));
    end

    assign owner_req = REQ[owner_q];
    assign limit_hit = (MAX_HOLD != 0) && (hold_q == CW'(MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        preempt_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_OWN;
                    gnt_d   = win_onehot;
                    owner_d = win_idx;
                    hold_d  = CW'(1);
                    ptr_d   = win_next;
                end
            end
            S_OWN: begin
                if (!owner_req || limit_hit) begin
                    state_d   = S_TURN;
                    gnt_d     = '0;
                    owner_d   = '0;
                    hold_d    = '0;
                    turn_d    = CW'(1);
                    // A simultaneous drop of REQ counts as a voluntary release.
                    preempt_d = limit_hit && owner_req;
                end else if (hold_q != {CW{1'b1}}) begin
                    hold_d = hold_q + CW'(1);
                end
            end
            S_TURN: begin
                if (turn_q == CW'(TURN_CYCLES)) begin
                    turn_d = '0;
                    if (win_found) begin
                        state_d = S_OWN;
                        gnt_d   = win_onehot;
                        owner_d = win_idx;
                        hold_d  = CW'(1);
                        ptr_d   = win_next;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    turn_d = turn_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                owner_d = '0;
                hold_d  = '0;
                turn_d  = '0;
            end
        endcase

        parked_d = ~|gnt_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            gnt_q     <= '0;
            owner_q   <= '0;
            preempt_q <= 1'b0;
            parked_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            preempt_q <= preempt_d;
            parked_q  <= parked_d;
        end
    end

    assign GNT     = gnt_q;
    assign OE      = gnt_q;
    assign OWNER   = owner_q;
    assign PARKED  = parked_q;
    assign PREEMPT = preempt_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter (N=4, TURN_CYCLES=2, MAX_HOLD=8):
// per-cycle expected grants are queued when driven and popped after the edge.
module tb_tristate_bus_arbiter;

    localparam int N    = 4;
    localparam int TURN = 2;

    typedef struct {
        logic [N-1:0] gnt;
        logic         pre;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] REQ = '0;
    logic [N-1:0] GNT;
    logic [N-1:0] OE;
    logic [1:0]   OWNER;
    logic         PARKED;
    logic         PREEMPT;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    bit   mon_en = 1'b0;
    logic rst_at_edge = 1'b1;

    tristate_bus_arbiter #(
        .N(N), .TURN_CYCLES(TURN), .MAX_HOLD(8), .CW(4)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .GNT(GNT), .OE(OE),
        .OWNER(OWNER), .PARKED(PARKED), .PREEMPT(PREEMPT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] owner_of(input logic [N-1:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < N; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    task automatic step(input logic rst, input logic [N-1:0] req,
                        input logic [N-1:0] g, input logic pre, input string tag);
        exp_t e;
        exp_t x;
        RST   = rst;
        REQ   = req;
        e.gnt = g;
        e.pre = pre;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        x = sb.pop_front();
        $display("%-14s rst=%b req=%b gnt=%b oe=%b owner=%0d parked=%b preempt=%b",
                 tag, rst, req, GNT, OE, OWNER, PARKED, PREEMPT);
        n_vec++;
        assert (GNT === x.gnt) else begin
            n_fail++; $error("FAIL %s gnt got=%b exp=%b", tag, GNT, x.gnt);
        end
        n_vec++;
        assert (OE === x.gnt) else begin
            n_fail++; $error("FAIL %s oe got=%b exp=%b", tag, OE, x.gnt);
        end
        n_vec++;
        assert (OWNER === owner_of(x.gnt)) else begin
            n_fail++; $error("FAIL %s owner got=%0d exp=%0d", tag, OWNER, owner_of(x.gnt));
        end
        n_vec++;
        assert (PARKED === (x.gnt == '0)) else begin
            n_fail++; $error("FAIL %s parked got=%b exp=%b", tag, PARKED, (x.gnt == '0));
        end
        n_vec++;
        assert (PREEMPT === x.pre) else begin
            n_fail++; $error("FAIL %s preempt got=%b exp=%b", tag, PREEMPT, x.pre);
        end
    endtask

    always @(posedge CLK) rst_at_edge <= RST;

    // Bus-safety invariants checked every cycle: one driver at most, keeper
    // flag consistent, and a full turnaround gap between different owners.
    logic [N-1:0] last_nz  = '0;
    int           zero_run = 0;
    always @(negedge CLK) begin
        if (mon_en) begin
            n_vec++;
            assert ($countones(OE) <= 1) else begin
                n_fail++; $error("FAIL inv_onehot oe=%b exp=at most one bit", OE);
            end
            n_vec++;
            assert (PARKED === ~|OE) else begin
                n_fail++; $error("FAIL inv_parked parked=%b exp=%b", PARKED, ~|OE);
            end
            if (rst_at_edge) begin
                last_nz  = '0;
                zero_run = 0;
            end else if (OE != '0) begin
                if (last_nz != '0 && OE != last_nz) begin
                    n_vec++;
                    assert (zero_run >= TURN) else begin
                        n_fail++; $error("FAIL inv_turn gap=%0d exp>=%0d", zero_run, TURN);
                    end
                end
                last_nz  = OE;
                zero_run = 0;
            end else begin
                zero_run++;
            end
        end
    end

    initial begin
        // Reset held with all requests up, then first grant one cycle later.
        step(1'b1, 4'b1111, 4'b0000, 1'b0, "rst0");
        mon_en = 1'b1;
        step(1'b1, 4'b1111, 4'b0000, 1'b0, "rst1");
        step(1'b0, 4'b1111, 4'b0001, 1'b0, "rst_grant");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "rst_rel");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "rst_turn");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "rst_idle");

        // Single requester, three cycles of ownership.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "reset");
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 4'b0100, 1'b0, "single_own");
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b0000, 1'b0, "single_off");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "single_idle");

        // Round robin with every requester asking; each owner holds two cycles.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "reset");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, oh(i % N), 1'b0, "rr_grant");
            step(1'b0, 4'b1111, oh(i % N), 1'b0, "rr_own2");
            step(1'b0, 4'b1111 & ~oh(i % N), 4'b0000, 1'b0, "rr_release");
            step(1'b0, 4'b1111, 4'b0000, 1'b0, "rr_turn");
        end

        // Sole requester hitting the hold limit repeatedly.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "reset");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) step(1'b0, 4'b0010, 4'b0010, 1'b0, "pre_own");
            step(1'b0, 4'b0010, 4'b0000, 1'b1, "pre_turn1");
            step(1'b0, 4'b0010, 4'b0000, 1'b0, "pre_turn2");
        end
        step(1'b0, 4'b0010, 4'b0010, 1'b0, "pre_regrant");

        // Preemption with a contender waiting.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "reset");
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0011, 4'b0001, 1'b0, "cont_own0");
        step(1'b0, 4'b0011, 4'b0000, 1'b1, "cont_turn1");
        step(1'b0, 4'b0011, 4'b0000, 1'b0, "cont_turn2");
        step(1'b0, 4'b0011, 4'b0010, 1'b0, "cont_own1");
        step(1'b0, 4'b0011, 4'b0010, 1'b0, "cont_own1b");

        // Owner drops request at the same edge the limit is reached.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "reset");
        for (int i = 0; i < 8; i++) step(1'b0, 4'b0001, 4'b0001, 1'b0, "sim_own");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "sim_release");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "sim_turn2");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "sim_idle");

        // Reset while requester 3 owns the bus.
        step(1'b1, 4'b0000, 4'b0000, 1'b0, "reset");
        step(1'b0, 4'b1000, 4'b1000, 1'b0, "mid_grant");
        step(1'b0, 4'b1000, 4'b1000, 1'b0, "mid_own");
        step(1'b1, 4'b1000, 4'b0000, 1'b0, "mid_reset");
        step(1'b0, 4'b1000, 4'b1000, 1'b0, "mid_regrant");
        step(1'b0, 4'b0000, 4'b0000, 1'b0, "mid_release");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
